// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: latency, blank value and the
// layout of the flat inter-stage data bus.
package mux_pkg;

   function automatic int unsigned lat_of(input int unsigned sw);
      return 1 + (sw + 1) / 2;
   endfunction

   // Value driven on every output bit while en_n is high.
   function automatic logic blank_bit(input int unsigned invert);
      return (invert != 0);
   endfunction

   // Number of channels still live at stage boundary b (b=0 is the input register).
   function automatic int unsigned bus_ch(input int unsigned nch, input int unsigned sw,
                                          input int unsigned b);
      int unsigned sh;
      sh = (2 * b < sw) ? 2 * b : sw;
      return nch >> sh;
   endfunction

   // Bit offset of boundary b inside the flat bus.
   function automatic int unsigned bus_off(input int unsigned nch, input int unsigned w,
                                           input int unsigned sw, input int unsigned b);
      int unsigned off;
      off = 0;
      for (int unsigned i = 0; i < b; i++) off += bus_ch(nch, sw, i) * w;
      return off;
   endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline slice of the mux tree: one or two 2:1 levels followed by a
// register that only captures valid beats.
module mux_tree_stage #(
   parameter int unsigned NIN    = 4,
   parameter int unsigned LEVELS = 2,
   parameter int unsigned W      = 1,
   parameter int unsigned SW     = 2,
   parameter int unsigned BIT0   = 0,
   parameter int unsigned INV    = 0,
   parameter logic        BLANK  = 1'b0,
   localparam int unsigned NOUT  = NIN >> LEVELS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NIN*W-1:0]  din,
   input  logic              in_valid,
   input  logic              in_en_n,
   input  logic [SW-1:0]     in_ch,
   output logic [NOUT*W-1:0] dout,
   output logic              out_valid,
   output logic [SW-1:0]     out_ch
);

   localparam int unsigned NMID = NIN / 2;

   logic [NMID*W-1:0] mid;
   logic [NOUT*W-1:0] pick;
   logic [NOUT*W-1:0] res;

   always_comb begin
      mid = '0;
      for (int unsigned j = 0; j < NMID; j++)
         mid[j*W +: W] = in_ch[BIT0] ? din[(2*j+1)*W +: W] : din[2*j*W +: W];
   end

   generate
      if (LEVELS == 2) begin : g_two
         always_comb begin
            pick = '0;
            for (int unsigned j = 0; j < NOUT; j++)
               pick[j*W +: W] = in_ch[BIT0+1] ? mid[(2*j+1)*W +: W] : mid[2*j*W +: W];
         end
      end else begin : g_one
         assign pick = mid;
      end
   endgenerate

   // Inversion commutes with selection, so it and blanking are applied where enabled.
   assign res = in_en_n ? {(NOUT*W){BLANK}} : ((INV != 0) ? ~pick : pick);

   always_ff @(posedge clk) begin
      if (rst) begin
         dout      <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            dout   <= res;
            out_ch <= in_ch;
         end
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NCH:1 mux tree with direct or auto-incrementing scan channel
// selection, optional output inversion and an active-low output enable.
module mux_tree_pipe import mux_pkg::*; #(
   parameter int unsigned NCH    = 16,
   parameter int unsigned W      = 1,
   parameter int unsigned INVERT = 1,
   localparam int unsigned SW    = $clog2(NCH),
   localparam int unsigned LAT   = lat_of(SW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*W-1:0]  din,
   input  logic              in_valid,
   input  logic [SW-1:0]     sel,
   input  logic              sel_load,
   input  logic              scan_en,
   input  logic              en_n,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic [SW-1:0]     out_ch
);

   localparam int unsigned NST = LAT - 1;
   localparam int unsigned TOT = bus_off(NCH, W, SW, NST + 1);

   logic [NCH*W-1:0] din_q;
   logic             en_q;
   logic             vld_q;
   logic [SW-1:0]    idx_q;
   logic [SW-1:0]    scan_idx;
   logic [SW-1:0]    eff_c;

   // Stage boundaries: each bit range has exactly one driver.
   wire [TOT-1:0] bus;
   wire [NST:0]   vld;
   wire [SW-1:0]  ch [NST+1];

   always_comb begin
      eff_c = sel;
      if (scan_en && !sel_load) eff_c = scan_idx;
   end

   // Input register and scan index; reset wins over loads and beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_q    <= '0;
         en_q     <= 1'b0;
         vld_q    <= 1'b0;
         idx_q    <= '0;
         scan_idx <= '0;
      end else begin
         din_q <= din;
         en_q  <= en_n;
         vld_q <= in_valid;
         idx_q <= eff_c;
         if (scan_en && in_valid) scan_idx <= eff_c + SW'(1);
         else if (sel_load)       scan_idx <= sel;
      end
   end

   assign bus[NCH*W-1:0] = din_q;
   assign vld[0]         = vld_q;
   assign ch[0]          = idx_q;

   for (genvar s = 0; s < NST; s++) begin : g_stage
      localparam int unsigned NIN   = bus_ch(NCH, SW, s);
      localparam int unsigned NOUT  = bus_ch(NCH, SW, s + 1);
      localparam int unsigned LVL   = (SW - 2 * s >= 2) ? 2 : 1;
      localparam int unsigned OFF_I = bus_off(NCH, W, SW, s);
      localparam int unsigned OFF_O = bus_off(NCH, W, SW, s + 1);

      mux_tree_stage #(
         .NIN    (NIN),
         .LEVELS (LVL),
         .W      (W),
         .SW     (SW),
         .BIT0   (2 * s),
         .INV    ((s == 0) ? INVERT : 0),
         .BLANK  (blank_bit(INVERT))
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .din       (bus[OFF_I +: NIN*W]),
         .in_valid  (vld[s]),
         .in_en_n   ((s == 0) ? en_q : 1'b0),
         .in_ch     (ch[s]),
         .dout      (bus[OFF_O +: NOUT*W]),
         .out_valid (vld[s+1]),
         .out_ch    (ch[s+1])
      );
   end

   assign out_data  = bus[TOT-1 -: W];
   assign out_valid = vld[NST];
   assign out_ch    = ch[NST];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: 16x1 inverting and true copies share one
// stimulus table; an 8x8 true copy covers wide channels.
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, sel_load, scan_en, en_n;
   logic [15:0] din;
   logic [3:0]  sel;
   logic        data_a, data_b, valid_a, valid_b;
   logic [3:0]  ch_a, ch_b;

   logic [63:0] din_c;
   logic [2:0]  sel_c;
   logic        in_valid_c, sel_load_c, scan_en_c, en_n_c;
   logic [7:0]  data_c;
   logic        valid_c;
   logic [2:0]  ch_c;

   int checks = 0;
   int errors = 0;

   mux_tree_pipe #(.NCH(16), .W(1), .INVERT(1)) dut_a (
      .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .sel(sel),
      .sel_load(sel_load), .scan_en(scan_en), .en_n(en_n),
      .out_data(data_a), .out_valid(valid_a), .out_ch(ch_a));

   mux_tree_pipe #(.NCH(16), .W(1), .INVERT(0)) dut_b (
      .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .sel(sel),
      .sel_load(sel_load), .scan_en(scan_en), .en_n(en_n),
      .out_data(data_b), .out_valid(valid_b), .out_ch(ch_b));

   mux_tree_pipe #(.NCH(8), .W(8), .INVERT(0)) dut_c (
      .clk(clk), .rst(rst), .din(din_c), .in_valid(in_valid_c), .sel(sel_c),
      .sel_load(sel_load_c), .scan_en(scan_en_c), .en_n(en_n_c),
      .out_data(data_c), .out_valid(valid_c), .out_ch(ch_c));

   typedef struct {
      logic [15:0] din;
      logic [3:0]  sel;
      logic        scan_en, sel_load, valid, en_n;
      logic        xv, xa, xb;
      logic [3:0]  xch;
   } row_t;

   row_t rows [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [15:0] d, input logic [3:0] s, input logic se, input logic sl,
                      input logic v, input logic en, input logic xv, input logic xa,
                      input logic xb, input logic [3:0] xch);
      row_t r;
      r.din = d; r.sel = s; r.scan_en = se; r.sel_load = sl; r.valid = v; r.en_n = en;
      r.xv = xv; r.xa = xa; r.xb = xb; r.xch = xch;
      rows.push_back(r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] pat;
      logic [15:0] inv;
      logic [2:0]  c_sel [4];
      logic        c_en  [4];
      logic [7:0]  c_exp [4];
      row_t        r;

      rst = 1'b1; din = '0; sel = '0; in_valid = 1'b0; sel_load = 1'b0; scan_en = 1'b0; en_n = 1'b0;
      din_c = '0; sel_c = '0; in_valid_c = 1'b0; sel_load_c = 1'b0; scan_en_c = 1'b0; en_n_c = 1'b0;
      #1;
      tick(); tick();
      chk("reset valid", 64'(valid_a), 64'(0));
      chk("reset data", 64'(data_a), 64'(0));
      chk("reset ch", 64'(ch_a), 64'(0));
      chk("reset data_c", 64'(data_c), 64'(0));
      chk("reset scan_idx", 64'(dut_a.scan_idx), 64'(0));
      rst = 1'b0;

      // Single-beat latency: output valid on exactly the third edge.
      din = 16'h0001; sel = 4'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat edge1 valid", 64'(valid_a), 64'(0));
      tick();
      chk("lat edge2 valid", 64'(valid_a), 64'(0));
      tick();
      chk("lat edge3 valid", 64'(valid_a), 64'(1));
      chk("lat edge3 data", 64'(data_a), 64'(0));
      chk("lat edge3 ch", 64'(ch_a), 64'(0));
      tick();
      chk("lat edge4 valid", 64'(valid_a), 64'(0));

      pat = 16'hA5C3;
      inv = 16'h5A3C;
      add(16'h0001, 4'd0, 0, 0, 1, 0, 1, 0, 1, 4'd0);
      for (int k = 0; k < 16; k++)
         add(pat, 4'(k), 0, 0, 1, 0, 1, inv[k], pat[k], 4'(k));
      add(16'h0000, 4'd5,  0, 0, 1, 1, 1, 1, 0, 4'd5);
      add(16'hFFFF, 4'd3,  0, 0, 1, 1, 1, 1, 0, 4'd3);
      add(16'hFFFF, 4'd9,  0, 0, 1, 0, 1, 0, 1, 4'd9);
      add(16'h0000, 4'd2,  0, 0, 0, 0, 0, 0, 1, 4'd9);
      add(16'h8000, 4'd15, 0, 0, 1, 0, 1, 0, 1, 4'd15);
      add(16'h8000, 4'd14, 0, 0, 1, 0, 1, 1, 0, 4'd14);
      add(pat,      4'd14, 1, 1, 1, 0, 1, 1, 0, 4'd14);
      add(pat,      4'd5,  1, 0, 1, 0, 1, 0, 1, 4'd15);
      add(pat,      4'd5,  1, 0, 1, 0, 1, 0, 1, 4'd0);
      add(pat,      4'd5,  1, 0, 1, 0, 1, 0, 1, 4'd1);
      add(pat,      4'd9,  0, 0, 1, 0, 1, 1, 0, 4'd9);
      add(pat,      4'd5,  1, 0, 1, 0, 1, 1, 0, 4'd2);
      add(pat,      4'd7,  1, 1, 0, 0, 0, 1, 0, 4'd2);
      add(pat,      4'd5,  1, 0, 1, 0, 1, 0, 1, 4'd7);

      for (int j = 0; j < rows.size() + 2; j++) begin
         if (j < rows.size()) begin
            din = rows[j].din; sel = rows[j].sel; scan_en = rows[j].scan_en;
            sel_load = rows[j].sel_load; in_valid = rows[j].valid; en_n = rows[j].en_n;
         end else begin
            in_valid = 1'b0; sel_load = 1'b0; scan_en = 1'b0; en_n = 1'b0;
         end
         tick();
         if (j >= 2) begin
            r = rows[j-2];
            chk($sformatf("row%0d valid", j-2), 64'(valid_a), 64'(r.xv));
            chk($sformatf("row%0d valid_b", j-2), 64'(valid_b), 64'(r.xv));
            chk($sformatf("row%0d data_inv", j-2), 64'(data_a), 64'(r.xa));
            chk($sformatf("row%0d data_true", j-2), 64'(data_b), 64'(r.xb));
            chk($sformatf("row%0d ch", j-2), 64'(ch_a), 64'(r.xch));
         end
      end

      // Reset with beats in flight, asserted together with a load and a beat.
      din = pat; scan_en = 1'b1; sel_load = 1'b1; sel = 4'd3; in_valid = 1'b1;
      tick();
      sel_load = 1'b0;
      tick();
      rst = 1'b1; sel_load = 1'b1; sel = 4'd9;
      tick();
      chk("rst flight valid", 64'(valid_a), 64'(0));
      chk("rst flight data", 64'(data_a), 64'(0));
      chk("rst flight ch", 64'(ch_a), 64'(0));
      chk("rst flight scan_idx", 64'(dut_a.scan_idx), 64'(0));
      rst = 1'b0; sel_load = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("post rst valid %0d", k), 64'(valid_a), 64'(0));
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; scan_en = 1'b0;
      tick(); tick();
      chk("post rst scan valid", 64'(valid_a), 64'(1));
      chk("post rst scan ch", 64'(ch_a), 64'(0));
      chk("post rst scan data_inv", 64'(data_a), 64'(0));
      chk("post rst scan data_true", 64'(data_b), 64'(1));

      // Wide channels on the 8x8 copy.
      for (int k = 0; k < 7; k++) din_c[k*8 +: 8] = 8'(17 * k);
      din_c[56 +: 8] = 8'h3C;
      c_sel = '{3'd7, 3'd2, 3'd7, 3'd0};
      c_en  = '{1'b0, 1'b0, 1'b1, 1'b0};
      c_exp = '{8'h3C, 8'h22, 8'h00, 8'h00};
      for (int j = 0; j < 6; j++) begin
         if (j < 4) begin
            sel_c = c_sel[j]; en_n_c = c_en[j]; in_valid_c = 1'b1;
         end else begin
            in_valid_c = 1'b0; en_n_c = 1'b0;
         end
         tick();
         if (j >= 2) begin
            chk($sformatf("wide%0d valid", j-2), 64'(valid_c), 64'(1));
            chk($sformatf("wide%0d data", j-2), 64'(data_c), 64'(c_exp[j-2]));
            chk($sformatf("wide%0d ch", j-2), 64'(ch_c), 64'(c_sel[j-2]));
         end
      end
      tick();
      chk("wide idle valid", 64'(valid_c), 64'(0));
      chk("wide hold data", 64'(data_c), 64'(8'h00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 Parameter NCH, default 16: number of input channels; SHALL be a power of two, 2..256.
REQ-002 Parameter W, default 1: bits per channel.
REQ-003 Parameter INVERT, default 1: 1 = output is inverted selected data; 0 = true data.
REQ-004 Localparam SW = log2(NCH): select width.
REQ-005 Localparam LAT = 1 + ceil(SW/2): latency in cycles.
REQ-006 Port clk, input, 1: single clock, all state on rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port din, input, NCH*W: channel k occupies bits [k*W +: W].
REQ-009 Port in_valid, input, 1: beat present this cycle.
REQ-010 Port sel, input, SW: channel select (direct mode) or scan load value.
REQ-011 Port sel_load, input, 1: load scan index from sel.
REQ-012 Port scan_en, input, 1: 0 = direct mode, 1 = scan mode.
REQ-013 Port en_n, input, 1: active-low strobe; 1 forces output to the blank value.
REQ-014 Port out_data, output, W: selected, optionally inverted, data.
REQ-015 Port out_valid, output, 1: out_data/out_ch valid.
REQ-016 Port out_ch, output, SW: channel index that produced out_data.

Function
REQ-017 Stage 0 SHALL register din, en_n, in_valid and the effective index on every cycle; no backpressure.
REQ-018 Effective index: direct mode = sel; scan mode = sel when sel_load=1, else scan_idx.
REQ-019 scan_idx SHALL advance to effective index+1 on every cycle with scan_en=1 and in_valid=1; wrap NCH-1 -> 0.
REQ-020 sel_load=1 with in_valid=0 SHALL load scan_idx=sel without advancing.
REQ-021 With scan_en=0, scan_idx SHALL hold, except sel_load=1 loads it.
REQ-022 Tree: SW levels of 2:1 selection; a register SHALL follow every second level and the final level.
REQ-023 out_valid SHALL equal in_valid delayed exactly LAT cycles; NCH=16 gives LAT=3.
REQ-024 Pipeline SHALL accept a new beat every cycle (throughput 1), including back-to-back channel changes.
REQ-025 out_ch SHALL be the effective index of the same beat, pipelined alongside the data.
REQ-026 out_data SHALL be ~din[ch] when INVERT=1, din[ch] when INVERT=0.
REQ-027 When en_n=1 for a beat, out_data SHALL be all-ones (INVERT=1) or all-zeros (INVERT=0); out_valid unaffected.
REQ-028 Data and out_ch registers SHALL update only for valid beats; they hold when invalid.

Reset
REQ-029 rst=1 at a clock edge SHALL clear all valid bits, scan_idx, out_ch and out_data to 0.
REQ-030 Beats in flight at reset SHALL be discarded; the first valid input after reset deasserts appears LAT cycles later.
REQ-031 rst SHALL take priority over sel_load and in_valid in the same cycle.

Structure
REQ-032 Shared package mux_pkg SHALL hold the LAT computation function and the blank-value function.
REQ-033 One sub-module mux_tree_stage (2-level 4:1 or 1-level 2:1 slice plus register) SHALL be instantiated per pipeline stage via generate.
REQ-034 No combinational path from any input to any output.

Verification
REQ-035 NCH=16, W=1, INVERT=1, direct mode: din=16'h0001, sel=0, en_n=0, valid pulse -> out_data=0, out_ch=0, out_valid high exactly 3 cycles later.
REQ-036 Sweep sel 0..15 back-to-back, din=16'hA5C3 -> out_data stream = ~din[sel], one per cycle, out_ch = 0..15 in order.
REQ-037 en_n=1 with din=16'h0000, sel=5 -> out_data=1, out_valid=1; repeat with INVERT=0 -> out_data=0.
REQ-038 Scan mode, sel_load=1 sel=14 with valid, then 3 more valid beats -> out_ch sequence 14,15,0,1 (wrap checked).
REQ-039 rst asserted for one cycle while 3 beats are in flight -> out_valid=0 for the next 3 cycles, scan_idx=0; the next scan beat reports out_ch=0.
REQ-040 NCH=8, W=8, INVERT=0: din channel 7 = 8'h3C, sel=7 -> out_data=8'h3C after LAT=3 cycles.
